pipe_controller: RTL and testbench

Pipelined control and hazard unit for the 5-stage MIPS-subset core. It sits upstream of the datapath. It decodes `Opcode`/`Funct` in Decode and carries the resulting control bits through its own E/M/W pipeline registers. It resolves data hazards by forwarding or a one-cycle load-use stall, and control hazards by flushing on taken branches and jumps.

---
 rtl/pipe_controller.sv | 212 +++++++++++++++++++++
 tb/tb_pipe_controller.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_controller.sv
// pipe_controller: Decode-stage control decoder, E/M/W control pipeline and
// hazard unit (forwarding, load-use stall, branch/jump flush) for a 5-stage MIPS subset.
module pipe_controller #(
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [5:0]      Opcode,
  input  logic [5:0]      Funct,
  input  logic [RA_W-1:0] RsD,
  input  logic [RA_W-1:0] RtD,
  input  logic [RA_W-1:0] RdD,
  input  logic            ZeroM,
  output logic            RegDstE,
  output logic            ALUSrcB,
  output logic [2:0]      ALUControlE,
  output logic            MemWrite,
  output logic            Branch,
  output logic            PCSrc,
  output logic            RegWriteW,
  output logic            MemToReg,
  output logic            j,
  output logic            StallF,
  output logic            StallD,
  output logic            FlushD,
  output logic [1:0]      ForwardAE,
  output logic [1:0]      ForwardBE,
  output logic            IllegalOp
);

  typedef struct packed {
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src;
    logic [2:0] alu_ctrl;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
  } ctrl_t;

  ctrl_t           ctrl_dec_s;
  logic            jump_dec_s, uses_rs_s, uses_rt_s, illegal_dec_s;
  logic            lwstall_s, pcsrc_s, stall_s, jump_s;
  logic [RA_W-1:0] write_reg_e_s;

  ctrl_t           ctrl_e_q, ctrl_e_d;
  logic [RA_W-1:0] rs_e_q, rs_e_d, rt_e_q, rt_e_d, rd_e_q, rd_e_d;
  logic            reg_write_m_q, reg_write_m_d, mem_to_reg_m_q, mem_to_reg_m_d;
  logic            mem_write_m_q, mem_write_m_d, branch_m_q, branch_m_d;
  logic [RA_W-1:0] write_reg_m_q, write_reg_m_d;
  logic            reg_write_w_q, reg_write_w_d, mem_to_reg_w_q, mem_to_reg_w_d;
  logic [RA_W-1:0] write_reg_w_q, write_reg_w_d;
  logic            illegal_q, illegal_d;

  // M-stage producer wins over W; register 0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] src,
                                         input logic rw_m, input logic [RA_W-1:0] wr_m,
                                         input logic rw_w, input logic [RA_W-1:0] wr_w);
    if (rw_m && (wr_m != '0) && (wr_m == src)) begin
      return 2'b10;
    end else if (rw_w && (wr_w != '0) && (wr_w == src)) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction

  always_comb begin
    ctrl_dec_s    = '0;
    jump_dec_s    = 1'b0;
    uses_rs_s     = 1'b0;
    uses_rt_s     = 1'b0;
    illegal_dec_s = 1'b0;
    case (Opcode)
      6'b000000: begin
        uses_rs_s            = 1'b1;
        uses_rt_s            = 1'b1;
        ctrl_dec_s.reg_write = 1'b1;
        ctrl_dec_s.reg_dst   = 1'b1;
        case (Funct)
          6'b100000: ctrl_dec_s.alu_ctrl = 3'b010;
          6'b100010: ctrl_dec_s.alu_ctrl = 3'b110;
          6'b100100: ctrl_dec_s.alu_ctrl = 3'b000;
          6'b100101: ctrl_dec_s.alu_ctrl = 3'b001;
          6'b101010: ctrl_dec_s.alu_ctrl = 3'b111;
          default: begin
            ctrl_dec_s    = '0;
            uses_rs_s     = 1'b0;
            uses_rt_s     = 1'b0;
            illegal_dec_s = 1'b1;
          end
        endcase
      end
      6'b100011: begin
        uses_rs_s             = 1'b1;
        ctrl_dec_s.reg_write  = 1'b1;
        ctrl_dec_s.alu_src    = 1'b1;
        ctrl_dec_s.mem_to_reg = 1'b1;
        ctrl_dec_s.alu_ctrl   = 3'b010;
      end
      6'b101011: begin
        uses_rs_s            = 1'b1;
        uses_rt_s            = 1'b1;
        ctrl_dec_s.mem_write = 1'b1;
        ctrl_dec_s.alu_src   = 1'b1;
        ctrl_dec_s.alu_ctrl  = 3'b010;
      end
      6'b000100: begin
        uses_rs_s           = 1'b1;
        uses_rt_s           = 1'b1;
        ctrl_dec_s.branch   = 1'b1;
        ctrl_dec_s.alu_ctrl = 3'b110;
      end
      6'b001000: begin
        uses_rs_s            = 1'b1;
        ctrl_dec_s.reg_write = 1'b1;
        ctrl_dec_s.alu_src   = 1'b1;
        ctrl_dec_s.alu_ctrl  = 3'b010;
      end
      6'b000010: jump_dec_s = 1'b1;
      default:   illegal_dec_s = 1'b1;
    endcase
  end

  assign write_reg_e_s = ctrl_e_q.reg_dst ? rd_e_q : rt_e_q;
  assign lwstall_s = ctrl_e_q.mem_to_reg & ctrl_e_q.reg_write &
                     ((uses_rs_s & (RsD == rt_e_q)) | (uses_rt_s & (RtD == rt_e_q)));
  // The branch redirect overrides the load-use stall; the jump yields to both.
  assign pcsrc_s = branch_m_q & ZeroM & ~reset;
  assign stall_s = lwstall_s & ~pcsrc_s & ~reset;
  assign jump_s  = jump_dec_s & ~stall_s & ~pcsrc_s & ~reset;

  always_comb begin
    if (lwstall_s || pcsrc_s) begin
      ctrl_e_d = '0;
      rs_e_d   = '0;
      rt_e_d   = '0;
      rd_e_d   = '0;
    end else begin
      ctrl_e_d = ctrl_dec_s;
      rs_e_d   = RsD;
      rt_e_d   = RtD;
      rd_e_d   = RdD;
    end
    if (pcsrc_s) begin
      reg_write_m_d  = 1'b0;
      mem_to_reg_m_d = 1'b0;
      mem_write_m_d  = 1'b0;
      branch_m_d     = 1'b0;
      write_reg_m_d  = '0;
    end else begin
      reg_write_m_d  = ctrl_e_q.reg_write;
      mem_to_reg_m_d = ctrl_e_q.mem_to_reg;
      mem_write_m_d  = ctrl_e_q.mem_write;
      branch_m_d     = ctrl_e_q.branch;
      write_reg_m_d  = write_reg_e_s;
    end
    reg_write_w_d  = reg_write_m_q;
    mem_to_reg_w_d = mem_to_reg_m_q;
    write_reg_w_d  = write_reg_m_q;
    illegal_d      = illegal_q | illegal_dec_s;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_e_q       <= '0;
      rs_e_q         <= '0;
      rt_e_q         <= '0;
      rd_e_q         <= '0;
      reg_write_m_q  <= 1'b0;
      mem_to_reg_m_q <= 1'b0;
      mem_write_m_q  <= 1'b0;
      branch_m_q     <= 1'b0;
      write_reg_m_q  <= '0;
      reg_write_w_q  <= 1'b0;
      mem_to_reg_w_q <= 1'b0;
      write_reg_w_q  <= '0;
      illegal_q      <= 1'b0;
    end else begin
      ctrl_e_q       <= ctrl_e_d;
      rs_e_q         <= rs_e_d;
      rt_e_q         <= rt_e_d;
      rd_e_q         <= rd_e_d;
      reg_write_m_q  <= reg_write_m_d;
      mem_to_reg_m_q <= mem_to_reg_m_d;
      mem_write_m_q  <= mem_write_m_d;
      branch_m_q     <= branch_m_d;
      write_reg_m_q  <= write_reg_m_d;
      reg_write_w_q  <= reg_write_w_d;
      mem_to_reg_w_q <= mem_to_reg_w_d;
      write_reg_w_q  <= write_reg_w_d;
      illegal_q      <= illegal_d;
    end
  end

  assign RegDstE     = ctrl_e_q.reg_dst;
  assign ALUSrcB     = ctrl_e_q.alu_src;
  assign ALUControlE = ctrl_e_q.alu_ctrl;
  assign MemWrite    = mem_write_m_q;
  assign Branch      = branch_m_q;
  assign PCSrc       = pcsrc_s;
  assign RegWriteW   = reg_write_w_q;
  assign MemToReg    = mem_to_reg_w_q;
  assign j           = jump_s;
  assign StallF      = stall_s;
  assign StallD      = stall_s;
  assign FlushD      = pcsrc_s | jump_s;
  assign ForwardAE   = fwd_sel(rs_e_q, reg_write_m_q, write_reg_m_q, reg_write_w_q, write_reg_w_q);
  assign ForwardBE   = fwd_sel(rt_e_q, reg_write_m_q, write_reg_m_q, reg_write_w_q, write_reg_w_q);
  assign IllegalOp   = illegal_q;

endmodule

// File: tb/tb_pipe_controller.sv
// tb_pipe_controller: directed instruction sequences checked every cycle against an
// instruction-level pipeline model, plus hand-computed spot values.
module tb_pipe_controller;

  typedef enum int {ADD, SUB, AND_, OR_, SLT, LW, SW, BEQ, ADDI, JMP, ILLOP, ILLFN} op_e;
  typedef struct { op_e op; int rs; int rt; int rd; } ins_t;
  typedef struct { bit rw; bit rdst; bit asrc; bit mw; bit m2r; bit br; bit [2:0] alu; int rs; int rt; int wr; } st_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] Opcode = 6'd0, Funct = 6'd0;
  logic [4:0] RsD = 5'd0, RtD = 5'd0, RdD = 5'd0;
  logic ZeroM = 1'b0;
  logic RegDstE, ALUSrcB, MemWrite, Branch, PCSrc, RegWriteW, MemToReg, j;
  logic StallF, StallD, FlushD, IllegalOp;
  logic [2:0] ALUControlE;
  logic [1:0] ForwardAE, ForwardBE;

  int checks = 0;
  int errors = 0;

  st_t me, mm, mw;
  bit mill;
  ins_t cur;
  bit zero_v;
  bit e_lws, e_pcs, e_stall, e_j, e_flush;
  bit [1:0] e_fa, e_fb;
  logic [7:0] o_rde, o_asrc, o_alu, o_mw, o_br, o_pcs, o_rww, o_m2r, o_j, o_sf, o_sd, o_fl, o_fa, o_fb, o_ill;

  pipe_controller #(.RA_W(5)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .RsD(RsD), .RtD(RtD), .RdD(RdD),
    .ZeroM(ZeroM), .RegDstE(RegDstE), .ALUSrcB(ALUSrcB), .ALUControlE(ALUControlE),
    .MemWrite(MemWrite), .Branch(Branch), .PCSrc(PCSrc), .RegWriteW(RegWriteW),
    .MemToReg(MemToReg), .j(j), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .IllegalOp(IllegalOp)
  );

  always #5 clk = ~clk;

  function automatic ins_t mk(op_e op, int rs, int rt, int rd);
    ins_t i;
    i.op = op; i.rs = rs; i.rt = rt; i.rd = rd;
    return i;
  endfunction

  function automatic logic [5:0] enc_op(op_e o);
    case (o)
      LW:      return 6'b100011;
      SW:      return 6'b101011;
      BEQ:     return 6'b000100;
      ADDI:    return 6'b001000;
      JMP:     return 6'b000010;
      ILLOP:   return 6'b111111;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic logic [5:0] enc_fn(op_e o);
    case (o)
      ADD:     return 6'b100000;
      SUB:     return 6'b100010;
      AND_:    return 6'b100100;
      OR_:     return 6'b100101;
      SLT:     return 6'b101010;
      ILLFN:   return 6'b000001;
      default: return 6'b010101;
    endcase
  endfunction

  function automatic bit is_r(op_e o);
    return (o == ADD) || (o == SUB) || (o == AND_) || (o == OR_) || (o == SLT);
  endfunction

  function automatic bit uses_rs(op_e o);
    return is_r(o) || (o == LW) || (o == SW) || (o == BEQ) || (o == ADDI);
  endfunction

  function automatic bit uses_rt(op_e o);
    return is_r(o) || (o == SW) || (o == BEQ);
  endfunction

  function automatic st_t bubble();
    st_t s;
    s.rw = 0; s.rdst = 0; s.asrc = 0; s.mw = 0; s.m2r = 0; s.br = 0; s.alu = 3'd0;
    s.rs = 0; s.rt = 0; s.wr = 0;
    return s;
  endfunction

  // Control meaning of each instruction class, straight from the decode table.
  function automatic st_t to_stage(ins_t i);
    st_t s = bubble();
    case (i.op)
      ADD:  begin s.rw = 1; s.rdst = 1; s.alu = 3'b010; end
      SUB:  begin s.rw = 1; s.rdst = 1; s.alu = 3'b110; end
      AND_: begin s.rw = 1; s.rdst = 1; s.alu = 3'b000; end
      OR_:  begin s.rw = 1; s.rdst = 1; s.alu = 3'b001; end
      SLT:  begin s.rw = 1; s.rdst = 1; s.alu = 3'b111; end
      LW:   begin s.rw = 1; s.asrc = 1; s.m2r = 1; s.alu = 3'b010; end
      SW:   begin s.mw = 1; s.asrc = 1; s.alu = 3'b010; end
      BEQ:  begin s.br = 1; s.alu = 3'b110; end
      ADDI: begin s.rw = 1; s.asrc = 1; s.alu = 3'b010; end
      default: ;
    endcase
    s.rs = i.rs; s.rt = i.rt;
    s.wr = s.rdst ? i.rd : i.rt;
    return s;
  endfunction

  function automatic bit [1:0] fwd(int src);
    if (mm.rw && mm.wr != 0 && mm.wr == src) return 2'b10;
    if (mw.rw && mw.wr != 0 && mw.wr == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    me = bubble(); mm = bubble(); mw = bubble(); mill = 0;
  endtask

  task automatic model_eval();
    if (reset) begin
      e_lws = 0; e_pcs = 0; e_stall = 0; e_j = 0; e_flush = 0; e_fa = 2'd0; e_fb = 2'd0;
    end else begin
      e_lws   = me.m2r && me.rw && ((uses_rs(cur.op) && cur.rs == me.rt) ||
                                   (uses_rt(cur.op) && cur.rt == me.rt));
      e_pcs   = mm.br && zero_v;
      e_stall = e_lws && !e_pcs;
      e_j     = (cur.op == JMP) && !e_stall && !e_pcs;
      e_flush = e_pcs || e_j;
      e_fa    = fwd(me.rs);
      e_fb    = fwd(me.rt);
    end
  endtask

  task automatic model_advance();
    if (reset) begin
      model_clear();
    end else begin
      mill = mill || (cur.op == ILLOP) || (cur.op == ILLFN);
      mw = mm;
      mm = e_pcs ? bubble() : me;
      me = (e_lws || e_pcs) ? bubble() : to_stage(cur);
    end
  endtask

  task automatic compare_outputs();
    o_rde = 8'(RegDstE); o_asrc = 8'(ALUSrcB); o_alu = 8'(ALUControlE); o_mw = 8'(MemWrite);
    o_br = 8'(Branch); o_pcs = 8'(PCSrc); o_rww = 8'(RegWriteW); o_m2r = 8'(MemToReg);
    o_j = 8'(j); o_sf = 8'(StallF); o_sd = 8'(StallD); o_fl = 8'(FlushD);
    o_fa = 8'(ForwardAE); o_fb = 8'(ForwardBE); o_ill = 8'(IllegalOp);
    check("RegDstE", o_rde, 8'(me.rdst));
    check("ALUSrcB", o_asrc, 8'(me.asrc));
    check("ALUControlE", o_alu, 8'(me.alu));
    check("MemWrite", o_mw, 8'(mm.mw));
    check("Branch", o_br, 8'(mm.br));
    check("PCSrc", o_pcs, 8'(e_pcs));
    check("RegWriteW", o_rww, 8'(mw.rw));
    check("MemToReg", o_m2r, 8'(mw.m2r));
    check("j", o_j, 8'(e_j));
    check("StallF", o_sf, 8'(e_stall));
    check("StallD", o_sd, 8'(e_stall));
    check("FlushD", o_fl, 8'(e_flush));
    check("ForwardAE", o_fa, 8'(e_fa));
    check("ForwardBE", o_fb, 8'(e_fb));
    check("IllegalOp", o_ill, 8'(mill));
  endtask

  // One Decode cycle: present the instruction, check at the falling edge, advance at the rising edge.
  task automatic step(ins_t ins, bit zero);
    cur = ins; zero_v = zero;
    Opcode = enc_op(ins.op); Funct = enc_fn(ins.op);
    RsD = 5'(ins.rs); RtD = 5'(ins.rt); RdD = 5'(ins.rd); ZeroM = zero;
    model_eval();
    @(negedge clk);
    compare_outputs();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic async_reset_check();
    #2;
    reset = 1'b1;
    model_clear();
    model_eval();
    #1;
    compare_outputs();
  endtask

  ins_t f;
  initial begin
    f = mk(OR_, 8, 9, 7);
    model_clear();
    // Reset held for two cycles with a jump presented in Decode.
    step(mk(JMP, 0, 0, 0), 1'b0);
    step(mk(JMP, 0, 0, 0), 1'b0);
    check("reset_j", o_j, 8'd0);
    check("reset_flush", o_fl, 8'd0);
    check("reset_fa", o_fa, 8'd0);
    check("reset_ill", o_ill, 8'd0);
    reset = 1'b0;

    // Decode sweep
    step(mk(ADD, 20, 21, 10), 1'b0);
    step(mk(SUB, 20, 21, 11), 1'b0);  check("alu_add", o_alu, 8'd2);
    step(mk(AND_, 20, 21, 12), 1'b0); check("alu_sub", o_alu, 8'd6);
    step(mk(OR_, 20, 21, 13), 1'b0);  check("alu_and", o_alu, 8'd0);
    step(mk(SLT, 20, 21, 14), 1'b0);  check("alu_or", o_alu, 8'd1);
    step(mk(LW, 20, 15, 0), 1'b0);    check("alu_slt", o_alu, 8'd7); check("regdst_r", o_rde, 8'd1);
    step(mk(SW, 20, 21, 0), 1'b0);    check("alusrc_lw", o_asrc, 8'd1);
    step(mk(ADDI, 20, 16, 0), 1'b0);
    step(mk(BEQ, 20, 21, 0), 1'b0);   check("memwrite_sw", o_mw, 8'd1);
    step(f, 1'b0); step(f, 1'b0); step(f, 1'b0); step(f, 1'b0);

    // Dependent ALU ops: M forward, W forward, $0 destination
    step(mk(ADD, 1, 2, 3), 1'b0); step(mk(SUB, 3, 5, 4), 1'b0); step(f, 1'b0);
    check("fwd_m", o_fa, 8'd2);
    step(f, 1'b0); step(f, 1'b0);
    step(mk(ADD, 1, 2, 3), 1'b0); step(f, 1'b0); step(mk(SUB, 3, 5, 4), 1'b0); step(f, 1'b0);
    check("fwd_w", o_fa, 8'd1);
    step(f, 1'b0); step(f, 1'b0);
    step(mk(ADD, 1, 2, 0), 1'b0); step(mk(SUB, 0, 5, 4), 1'b0); step(f, 1'b0);
    check("fwd_r0", o_fa, 8'd0);
    step(f, 1'b0); step(f, 1'b0);

    // Load-use: one stall cycle, bubble in E, then W forward
    step(mk(LW, 1, 2, 0), 1'b0);
    step(mk(ADD, 3, 2, 4), 1'b0);
    check("lw_stallf", o_sf, 8'd1); check("lw_stalld", o_sd, 8'd1);
    step(mk(ADD, 3, 2, 4), 1'b0);
    check("lw_stall_once", o_sf, 8'd0); check("lw_bubble_alu", o_alu, 8'd0);
    step(f, 1'b0);
    check("lw_fwd_b", o_fb, 8'd1);
    step(f, 1'b0); step(f, 1'b0); step(f, 1'b0);

    // Taken beq with a concurrent load-use in Decode/Execute
    step(mk(BEQ, 1, 2, 0), 1'b1); step(mk(LW, 1, 2, 0), 1'b1); step(mk(ADD, 3, 2, 4), 1'b1);
    check("br_pcsrc", o_pcs, 8'd1); check("br_flush", o_fl, 8'd1); check("br_nostall", o_sf, 8'd0);
    step(f, 1'b1);
    check("br_e_bubble", o_asrc, 8'd0); check("br_m_bubble", o_br, 8'd0); check("br_pcsrc_once", o_pcs, 8'd0);
    step(f, 1'b1);
    check("br_w_killed", o_m2r, 8'd0); check("br_w_killed_rw", o_rww, 8'd0);
    step(f, 1'b0); step(f, 1'b0);

    // Jump: one-cycle flush, proceeds as NOP
    step(mk(JMP, 0, 0, 0), 1'b0); check("j_taken", o_j, 8'd1); check("j_flush", o_fl, 8'd1);
    step(f, 1'b0); check("j_once", o_j, 8'd0); check("j_e_nop", o_rde, 8'd0);
    step(f, 1'b0); check("j_m_nop", o_mw, 8'd0);
    step(f, 1'b0); check("j_w_nop", o_rww, 8'd0);
    // Branch in M beats jump in Decode
    step(mk(BEQ, 1, 2, 0), 1'b1); step(f, 1'b1); step(mk(JMP, 0, 0, 0), 1'b1);
    check("jb_pcsrc", o_pcs, 8'd1); check("jb_j", o_j, 8'd0); check("jb_flush", o_fl, 8'd1);
    step(f, 1'b0); step(f, 1'b0); step(f, 1'b0);

    // Undefined funct, then asynchronous reset mid-pipeline
    step(mk(ILLFN, 1, 2, 3), 1'b0); check("ill_pre", o_ill, 8'd0);
    step(mk(ADD, 1, 2, 3), 1'b0); check("illfn_set", o_ill, 8'd1); check("illfn_nop", o_rde, 8'd0);
    step(mk(SUB, 3, 5, 4), 1'b0);
    async_reset_check();
    check("arst_ill", o_ill, 8'd0); check("arst_rde", o_rde, 8'd0); check("arst_rww", o_rww, 8'd0);
    step(f, 1'b0);
    reset = 1'b0;

    // Undefined opcode behaves as NOP through W and latches IllegalOp
    step(mk(ILLOP, 0, 0, 0), 1'b0);
    step(f, 1'b0); check("illop_set", o_ill, 8'd1); check("illop_e", o_alu, 8'd0);
    step(f, 1'b0);
    step(f, 1'b0); check("illop_w", o_rww, 8'd0); check("illop_sticky", o_ill, 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
